pix_stream_src: RTL and testbench

- Raster pixel source feeding the 3x3 convolution datapath.
- Reads one RGB frame from a frame memory with a 1-cycle read latency, one pixel per address.
- Emits the frame as a per-channel 16-bit pixel stream with a valid strobe, row-major, one pixel per clock within a line.
- Inserts programmable horizontal blanking between lines so the downstream line buffers see clean line boundaries.

---
 rtl/pix_pkg.sv | 29 ++
 rtl/pix_raster_cnt.sv | 66 ++++++
 rtl/pix_stream_src.sv | 226 ++++++++++++++++++++++
 tb/tb_pix_stream_src.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared types for the raster pixel source: FSM state encoding, default
// channel width, RGB pixel struct and a counter-width helper.
package pix_pkg;

    localparam int PIX_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DRAIN  = 2'd3
    } pix_state_t;

    typedef struct packed {
        logic [PIX_DW-1:0] r;
        logic [PIX_DW-1:0] g;
        logic [PIX_DW-1:0] b;
    } rgb_t;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pix_raster_cnt.sv
// Raster position counters for pix_stream_src: column, row and linear
// memory address, with end-of-line / end-of-frame decodes. The counters
// hold on the final pixel so the address never wraps inside a frame.
module pix_raster_cnt #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int AW    = 19,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [AW-1:0] addr,
    output logic          eol,
    output logic          eof
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [AW-1:0] addr_r;
    logic          eol_s;
    logic          eof_s;

    assign eol_s = (col_r == COL_LAST);
    assign eof_s = eol_s && (row_r == ROW_LAST);

    // Advance the raster position once per streamed pixel; restart on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r  <= '0;
            row_r  <= '0;
            addr_r <= '0;
        end else if (clear) begin
            col_r  <= '0;
            row_r  <= '0;
            addr_r <= '0;
        end else if (step && !eof_s) begin
            addr_r <= addr_r + AW'(1);
            if (eol_s) begin
                col_r <= '0;
                row_r <= row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
                row_r <= row_r;
            end
        end else begin
            col_r  <= col_r;
            row_r  <= row_r;
            addr_r <= addr_r;
        end
    end

    assign col  = col_r;
    assign row  = row_r;
    assign addr = addr_r;
    assign eol  = eol_s;
    assign eof  = eof_s;

endmodule

// File: rtl/pix_stream_src.sv
// Raster pixel source: reads one RGB frame from a 1-cycle-latency frame
// memory and emits it as a row-major pixel stream with sof/eol sideband
// and programmable horizontal blanking between lines.
// Optional build macro PIX_SRC_TEST_PATTERN_EN adds a pattern_sel input
// that replaces memory data with a col/row test pattern.
module pix_stream_src
    import pix_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DW     = PIX_DW,
    parameter int AW     = 19,
    parameter int HBLANK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef PIX_SRC_TEST_PATTERN_EN
    input  logic          pattern_sel,
`endif
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata_r,
    input  logic [DW-1:0] mem_rdata_g,
    input  logic [DW-1:0] mem_rdata_b,
    output logic [DW-1:0] data_out_r,
    output logic [DW-1:0] data_out_g,
    output logic [DW-1:0] data_out_b,
    output logic          data_out_en,
    output logic          sof,
    output logic          eol
);

    localparam int         CW      = cnt_width(IMG_W);
    localparam int         RW      = cnt_width(IMG_H);
    localparam bit         HB_EN   = (HBLANK > 0);
    localparam logic [7:0] HB_LAST = (HBLANK > 0) ? 8'(HBLANK - 1) : 8'd0;

    // Control state
    pix_state_t    state_r, state_nxt_s;
    logic [7:0]    hb_cnt_r, hb_cnt_nxt_s;
    logic          drain_cnt_r, drain_cnt_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          done_r, done_nxt_s;
    logic          rd_en_r, rd_en_nxt_s;
    logic          pat_sel_r, pat_nxt_s;
    logic          pat_in_s;
    logic          start_acc_s;
    logic          step_s;

    // Raster counters
    logic [CW-1:0] col_s;
    logic [RW-1:0] row_s;
    logic [AW-1:0] addr_s;
    logic          eol_s;
    logic          eof_s;

    // Output pipeline
    logic          v1_r, sof1_r, eol1_r;
    logic [CW-1:0] col1_r;
    logic [RW-1:0] row1_r;
    logic          out_en_r, sof_r, eol_r;
    logic [DW-1:0] out_r_r, out_g_r, out_b_r;

`ifdef PIX_SRC_TEST_PATTERN_EN
    assign pat_in_s = pattern_sel;
`else
    assign pat_in_s = 1'b0;
`endif

    // A start is taken only from a settled IDLE, never in the done cycle.
    assign start_acc_s = start && (state_r == ST_IDLE) && !done_r;
    assign step_s      = (state_r == ST_ACTIVE);

    pix_raster_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW),
        .CW    (CW),
        .RW    (RW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc_s),
        .step  (step_s),
        .col   (col_s),
        .row   (row_s),
        .addr  (addr_s),
        .eol   (eol_s),
        .eof   (eof_s)
    );

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        hb_cnt_nxt_s    = hb_cnt_r;
        drain_cnt_nxt_s = drain_cnt_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        pat_nxt_s       = pat_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_nxt_s = ST_ACTIVE;
                    busy_nxt_s  = 1'b1;
                    pat_nxt_s   = pat_in_s;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (eof_s) begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = 1'b0;
                end else if (eol_s && HB_EN) begin
                    state_nxt_s  = ST_HBLANK;
                    hb_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s  = ST_ACTIVE;
                end
            end
            ST_HBLANK: begin
                if (hb_cnt_r == HB_LAST) begin
                    state_nxt_s  = ST_ACTIVE;
                end else begin
                    hb_cnt_nxt_s = hb_cnt_r + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                end else begin
                    drain_cnt_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
        rd_en_nxt_s = (state_nxt_s == ST_ACTIVE) && !pat_nxt_s;
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hb_cnt_r    <= 8'd0;
            drain_cnt_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            pat_sel_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hb_cnt_r    <= hb_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            rd_en_r     <= rd_en_nxt_s;
            pat_sel_r   <= pat_nxt_s;
        end
    end

    // Stage 1: capture valid, sideband and position alongside the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            sof1_r <= 1'b0;
            eol1_r <= 1'b0;
            col1_r <= '0;
            row1_r <= '0;
        end else begin
            v1_r   <= step_s;
            sof1_r <= step_s && (col_s == '0) && (row_s == '0);
            eol1_r <= step_s && eol_s;
            col1_r <= col_s;
            row1_r <= row_s;
        end
    end

    // Stage 2: sample returned memory data (or the pattern); hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_r <= 1'b0;
            sof_r    <= 1'b0;
            eol_r    <= 1'b0;
            out_r_r  <= '0;
            out_g_r  <= '0;
            out_b_r  <= '0;
        end else begin
            out_en_r <= v1_r;
            sof_r    <= sof1_r;
            eol_r    <= eol1_r;
            if (v1_r && pat_sel_r) begin
                out_r_r <= DW'(col1_r);
                out_g_r <= DW'(row1_r);
                out_b_r <= DW'(col1_r) + DW'(row1_r);
            end else if (v1_r) begin
                out_r_r <= mem_rdata_r;
                out_g_r <= mem_rdata_g;
                out_b_r <= mem_rdata_b;
            end else begin
                out_r_r <= out_r_r;
                out_g_r <= out_g_r;
                out_b_r <= out_b_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_rd_en   = rd_en_r;
    assign mem_addr    = addr_s;
    assign data_out_r  = out_r_r;
    assign data_out_g  = out_g_r;
    assign data_out_b  = out_b_r;
    assign data_out_en = out_en_r;
    assign sof         = sof_r;
    assign eol         = eol_r;

endmodule

// File: tb/tb_pix_stream_src.sv
// Self-checking bench for pix_stream_src: two 4x3 instances (HBLANK=2 and
// HBLANK=0) fed by a behavioural frame memory; expected timing and data are
// computed from raster arithmetic and compared with immediate assertions.
module tb_pix_stream_src;
    import pix_pkg::*;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, start0, start1;
`ifdef PIX_SRC_TEST_PATTERN_EN
    logic pat0, pat1;
`endif
    logic        busy0, done0, rd0, en0, sof0, eol0;
    logic        busy1, done1, rd1, en1, sof1, eol1;
    logic [18:0] addr0, addr1;
    logic [15:0] dr0, dg0, db0, dr1, dg1, db1;
    rgb_t        rdata0, rdata1;

    rgb_t mem [2][NPIX];

    pix_stream_src #(.IMG_W(W), .IMG_H(H), .DW(16), .AW(19), .HBLANK(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
`ifdef PIX_SRC_TEST_PATTERN_EN
        .pattern_sel(pat0),
`endif
        .busy(busy0), .done(done0), .mem_rd_en(rd0), .mem_addr(addr0),
        .mem_rdata_r(rdata0.r), .mem_rdata_g(rdata0.g), .mem_rdata_b(rdata0.b),
        .data_out_r(dr0), .data_out_g(dg0), .data_out_b(db0),
        .data_out_en(en0), .sof(sof0), .eol(eol0)
    );

    pix_stream_src #(.IMG_W(W), .IMG_H(H), .DW(16), .AW(19), .HBLANK(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef PIX_SRC_TEST_PATTERN_EN
        .pattern_sel(pat1),
`endif
        .busy(busy1), .done(done1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rdata_r(rdata1.r), .mem_rdata_g(rdata1.g), .mem_rdata_b(rdata1.b),
        .data_out_r(dr1), .data_out_g(dg1), .data_out_b(db1),
        .data_out_en(en1), .sof(sof1), .eol(eol1)
    );

    function automatic rgb_t mem_rd(input int inst, input logic [18:0] a);
        if (a < 19'(NPIX)) return mem[inst][int'(a)];
        else return '0;
    endfunction

    // Frame memory: 1-cycle read latency, junk on the bus when not reading.
    always @(posedge clk) begin
        rdata0 <= rd0 ? mem_rd(0, addr0) : rgb_t'({16'($urandom), 16'($urandom), 16'($urandom)});
        rdata1 <= rd1 ? mem_rd(1, addr1) : rgb_t'({16'($urandom), 16'($urandom), 16'($urandom)});
    end

    typedef struct {int inst; int cyc; rgb_t px; logic sof; logic eol;} px_ev_t;
    typedef struct {int inst; int cyc; int addr;} ev_t;
    px_ev_t px_q[$];
    ev_t    rd_q[$];
    ev_t    done_q[$];
    ev_t    busy_q[$];

    // Event recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (en0)   px_q.push_back('{0, cyc, rgb_t'({dr0, dg0, db0}), sof0, eol0});
        if (en1)   px_q.push_back('{1, cyc, rgb_t'({dr1, dg1, db1}), sof1, eol1});
        if (rd0)   rd_q.push_back('{0, cyc, int'(addr0)});
        if (rd1)   rd_q.push_back('{1, cyc, int'(addr1)});
        if (done0) done_q.push_back('{0, cyc, 0});
        if (done1) done_q.push_back('{1, cyc, 0});
        if (busy0) busy_q.push_back('{0, cyc, 0});
        if (busy1) busy_q.push_back('{1, cyc, 0});
    end

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        px_q.delete(); rd_q.delete(); done_q.delete(); busy_q.delete();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int inst, output int s);
        s = cyc;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic fill_mem(input int inst, input bit by_addr);
        for (int p = 0; p < NPIX; p++) begin
            if (by_addr) mem[inst][p] = '{r: 16'(p), g: 16'(p + 100), b: 16'(p + 200)};
            else mem[inst][p] = rgb_t'({16'($urandom), 16'($urandom), 16'($urandom)});
        end
    endtask

    // Expected frame: pixel p at (p%W, p/W) is read at s+1+p+row*hb and
    // appears two cycles later; done follows the last pixel by one cycle.
    task automatic check_frame(input int inst, input int s, input int hb, input bit pat, input string tag);
        px_ev_t px[$];
        ev_t rd[$];
        ev_t dn[$];
        ev_t bz[$];
        int exp_done;
        foreach (px_q[i])   if (px_q[i].inst == inst)   px.push_back(px_q[i]);
        foreach (rd_q[i])   if (rd_q[i].inst == inst)   rd.push_back(rd_q[i]);
        foreach (done_q[i]) if (done_q[i].inst == inst) dn.push_back(done_q[i]);
        foreach (busy_q[i]) if (busy_q[i].inst == inst) bz.push_back(busy_q[i]);
        chk({tag, " px_count"}, px.size(), NPIX);
        chk({tag, " rd_count"}, rd.size(), pat ? 0 : NPIX);
        for (int p = 0; p < NPIX; p++) begin
            int row, col, rdc;
            rgb_t e;
            row = p / W;
            col = p % W;
            rdc = s + 1 + p + row * hb;
            if (pat) e = '{r: 16'(col), g: 16'(row), b: 16'(col + row)};
            else e = mem[inst][p];
            if (p < px.size()) begin
                chk({tag, " px_cycle"}, px[p].cyc, rdc + 2);
                chk({tag, " r"}, px[p].px.r, e.r);
                chk({tag, " g"}, px[p].px.g, e.g);
                chk({tag, " b"}, px[p].px.b, e.b);
                chk({tag, " sof"}, px[p].sof, (p == 0) ? 1 : 0);
                chk({tag, " eol"}, px[p].eol, (col == W - 1) ? 1 : 0);
            end
            if (p < rd.size()) begin
                chk({tag, " rd_addr"}, rd[p].addr, p);
                chk({tag, " rd_cycle"}, rd[p].cyc, rdc);
            end
        end
        exp_done = s + 1 + (NPIX - 1) + (H - 1) * hb + 3;
        chk({tag, " done_count"}, dn.size(), 1);
        if (dn.size() > 0) chk({tag, " done_cycle"}, dn[0].cyc, exp_done);
        chk({tag, " busy_cycles"}, bz.size(), exp_done - s - 1);
        if (bz.size() > 0) chk({tag, " busy_first"}, bz[0].cyc, s + 1);
        clear_q();
    endtask

    initial begin
        int s;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
`ifdef PIX_SRC_TEST_PATTERN_EN
        pat0 = 1'b0;
        pat1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst rd_en", rd0, 0);
        chk("rst addr", addr0, 0);
        chk("rst data", {dr0, dg0, db0}, 0);
        chk("rst en", en0, 0);
        chk("rst sof_eol", {sof0, eol0, sof1, eol1}, 0);
        chk("rst busy1", {busy1, en1, rd1}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_q();

        // Basic frame with HBLANK=2, r=addr data
        fill_mem(0, 1'b1);
        pulse_start(0, s);
        wait_until(s + 40);
        check_frame(0, s, 2, 1'b0, "hb2");

        // HBLANK=0: 12 contiguous pixels
        fill_mem(1, 1'b0);
        pulse_start(1, s);
        wait_until(s + 40);
        check_frame(1, s, 0, 1'b0, "hb0");

        // Start re-pulsed mid-frame and in the done cycle is ignored
        fill_mem(0, 1'b0);
        pulse_start(0, s);
        wait_until(s + 10);
        start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
        wait_until(s + 19);
        start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
        wait_until(s + 60);
        check_frame(0, s, 2, 1'b0, "restart_ign");
        pulse_start(0, s);
        wait_until(s + 40);
        check_frame(0, s, 2, 1'b0, "frame2");

        // Reset during row 1 truncates the frame asynchronously
        pulse_start(0, s);
        wait_until(s + 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", busy0, 0);
        chk("mid_rst rd_en", rd0, 0);
        chk("mid_rst addr", addr0, 0);
        chk("mid_rst data", {dr0, dg0, db0}, 0);
        chk("mid_rst en_sof_eol_done", {en0, sof0, eol0, done0}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_until(cyc + 30);
        chk("mid_rst no_done", done_q.size(), 0);
        clear_q();
        fill_mem(0, 1'b0);
        pulse_start(0, s);
        wait_until(s + 40);
        check_frame(0, s, 2, 1'b0, "after_rst");

`ifdef PIX_SRC_TEST_PATTERN_EN
        // Test pattern: sampled at start, held even if pattern_sel drops
        pat0 = 1'b1;
        pulse_start(0, s);
        pat0 = 1'b0;
        wait_until(s + 40);
        check_frame(0, s, 2, 1'b1, "pattern");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
